alu_seq_exec: RTL and testbench



---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_comb_unit.sv | 48 ++++
 rtl/alu_seq_exec.sv | 121 ++++++++++++
 tb/tb_alu_seq_exec.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------+
// | alu_pkg : op codes, FSM states and shift helpers for alu_seq_exec   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int SHAMT_W = 5;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_XOR = 4'b0001,
    OP_ADD = 4'b0010,
    OP_OR  = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SRA = 4'b0111,
    OP_EQ  = 4'b1000,
    OP_SLT = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // One step of the iterative shifter; SRA replicates the sign bit.
  function automatic logic [31:0] shift_one(input logic [31:0] v, input logic [3:0] op);
    case (op)
      OP_SLL:  return {v[30:0], 1'b0};
      OP_SRL:  return {1'b0, v[31:1]};
      OP_SRA:  return {v[31], v[31:1]};
      default: return v;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_comb_unit.sv
// +--------------------------------------------------------------------+
// | alu_comb_unit : single-cycle ALU result (barrel shift if            |
// | ALU_BARREL_SHIFT_EN, otherwise shifts pass SrcA for shamt==0)       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_comb_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o
);

`ifdef ALU_BARREL_SHIFT_EN
  logic [SHAMT_W-1:0] shamt;
  assign shamt = b_i[SHAMT_W-1:0];
`endif

  always_comb begin
    result_o = '0;
    case (op_i)
      OP_AND: result_o = a_i & b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_ADD: result_o = a_i + b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_SUB: result_o = a_i - b_i;
      OP_EQ:  result_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
      OP_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL: result_o = a_i << shamt;
      OP_SRL: result_o = a_i >> shamt;
      OP_SRA: result_o = $signed(a_i) >>> shamt;
`else
      // Only reached with shamt==0; non-zero amounts go through the shift loop.
      OP_SLL, OP_SRL, OP_SRA: result_o = a_i;
`endif
      default: result_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq_exec.sv
// +--------------------------------------------------------------------+
// | alu_seq_exec : execute-stage ALU with valid/ready handshake;        |
// | ALU_BARREL_SHIFT_EN selects 1-cycle barrel shifts. Rev 1.0          |
// +--------------------------------------------------------------------+
`default_nettype none

module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        Operation,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALUResult,
  output logic              Zero
);

  alu_state_e        state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
  logic [DATA_W-1:0] comb_result;

  alu_comb_unit #(.DATA_W(DATA_W)) u_comb (
    .op_i     (Operation),
    .a_i      (SrcA),
    .b_i      (SrcB),
    .result_o (comb_result)
  );

`ifndef ALU_BARREL_SHIFT_EN
  logic [DATA_W-1:0]  acc_q, acc_d, acc_shifted;
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] shamt;

  assign shamt       = SrcB[SHAMT_W-1:0];
  assign acc_shifted = shift_one(acc_q, op_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
      acc_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifndef ALU_BARREL_SHIFT_EN
      acc_q    <= acc_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifndef ALU_BARREL_SHIFT_EN
    acc_d    = acc_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
`ifndef ALU_BARREL_SHIFT_EN
          if (is_shift(Operation) && (shamt != '0)) begin
            acc_d   = SrcA;
            op_d    = Operation;
            cnt_d   = shamt;
            state_d = ST_SHIFT;
          end else
`endif
          begin
            result_d = comb_result;
            zero_d   = (comb_result == '0);
            state_d  = ST_DONE;
          end
        end
      end
`ifndef ALU_BARREL_SHIFT_EN
      ST_SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = acc_shifted;
          zero_d   = (acc_shifted == '0);
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_exec.sv
// +--------------------------------------------------------------------+
// | tb_alu_seq_exec : directed + random checks of alu_seq_exec against  |
// | an arithmetic reference model. Rev 1.0                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  Operation = 4'h0;
  logic [31:0] SrcA = 32'h0;
  logic [31:0] SrcB = 32'h0;
  logic        in_ready, out_valid, Zero;
  logic [31:0] ALUResult;

  int vectors = 0;
  int miscompares = 0;

  alu_seq_exec #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'h0: return a & b;
      4'h1: return a ^ b;
      4'h2: return a + b;
      4'h3: return a | b;
      4'h4: return a << sh;
      4'h5: return a >> sh;
      4'h6: return a - b;
      4'h7: return $signed(a) >>> sh;
      4'h8: return (a == b) ? 32'd1 : 32'd0;
      4'hD: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    if ((op == 4'h4 || op == 4'h5 || op == 4'h7) && b[4:0] != 5'd0)
      return 1 + int'(b[4:0]);
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one op, measure latency, check result, optionally stall in DONE.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp_r;
    int          exp_lat;
    int          lat;
    exp_r   = model(op, a, b);
    exp_lat = model_latency(op, b);
    @(negedge clk);
    check1("in_ready_idle", in_ready, 1'b1);
    check1("out_valid_idle", out_valid, 1'b0);
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      check1("in_ready_busy", in_ready, 1'b0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", ALUResult, exp_r);
    check1("zero", Zero, exp_r == 32'd0);
    check1("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      Operation = 4'h2; SrcA = $urandom; SrcB = $urandom;
      @(negedge clk);
      check("hold_result", ALUResult, exp_r);
      check1("hold_valid", out_valid, 1'b1);
      check1("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check1("handoff_valid", out_valid, 1'b0);
    check1("handoff_ready", in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ops [12];
    logic [31:0] a, b;
    ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hD, 4'h9, 4'hF};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check("rst_result", ALUResult, 32'h0);
    check1("rst_zero", Zero, 1'b1);

    run_op(4'h2, 32'hFFFF_FFFF, 32'h1, 0);
    run_op(4'h6, 32'd5, 32'd7, 0);
    run_op(4'hD, 32'h8000_0000, 32'h1, 0);
    run_op(4'h8, 32'h1234, 32'h1234, 0);
    run_op(4'h7, 32'h8000_0000, 32'd31, 0);
    run_op(4'h4, 32'h1, 32'h20, 0);
    run_op(4'h3, 32'hA5A5_0000, 32'h0000_5A5A, 5);
    run_op(4'hA, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Reset while an SRL is in flight: nothing may be emitted for it.
    @(negedge clk);
    Operation = 4'h5; SrcA = 32'hF0; SrcB = 32'd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check1("midrst_out_valid", out_valid, 1'b0);
    check1("midrst_in_ready", in_ready, 1'b1);
    check("midrst_result", ALUResult, 32'h0);
    check1("midrst_zero", Zero, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check1("midrst_no_emit", out_valid, 1'b0);
    end
    run_op(4'h1, 32'hF0, 32'hFF, 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      if (n % 5 == 0) b = a;
      if (n % 7 == 0) a = 32'h8000_0000 | a;
      run_op(ops[$urandom_range(0, 11)], a, b, $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
